// File: rtl/jtkiwi_gfx_romrq_pkg.sv
// Shared types and helpers for the Kiwi graphics ROM request responder.
package jtkiwi_gfx_romrq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_t;

  localparam logic CL_SCR = 1'b0;
  localparam logic CL_OBJ = 1'b1;

  // 32-bit word address to 16-bit SDRAM word address, wrapping modulo 2^22
  function automatic logic [21:0] map_addr(input logic [17:0] addr, input logic [21:0] offset);
    return {3'b000, addr, 1'b0} + offset;
  endfunction

endpackage

// File: rtl/jtkiwi_romrq_slot.sv
// One-entry tag cache for a single ROM client: tag, valid, data and hit compare.
module jtkiwi_romrq_slot
(
  input  logic        rst,
  input  logic        clk,
  input  logic [17:0] addr,
  input  logic        cs,
  input  logic        fill,
  input  logic [17:0] fill_tag,
  input  logic [31:0] fill_data,
  output logic        ok,
  output logic [31:0] data
);

  logic [17:0] tag_r;
  logic        valid_r;

  // Cache entry update on fill completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r   <= 18'd0;
      valid_r <= 1'b0;
      data    <= 32'd0;
    end else if (fill) begin
      tag_r   <= fill_tag;
      valid_r <= 1'b1;
      data    <= fill_data;
    end else begin
      tag_r   <= tag_r;
      valid_r <= valid_r;
      data    <= data;
    end
  end

  assign ok = cs & valid_r & (tag_r == addr);

endmodule

// File: rtl/jtkiwi_gfx_romrq.sv
// Serves the scroll and object ROM clients from one 16-bit SDRAM read port,
// with a one-entry cache per client and round-robin arbitration on misses.
module jtkiwi_gfx_romrq
  import jtkiwi_gfx_romrq_pkg::*;
#(
  parameter logic [21:0] SCR_OFFSET = 22'h000000,
  parameter logic [21:0] OBJ_OFFSET = 22'h080000
)(
  input  logic        rst,
  input  logic        clk,
  input  logic [17:0] scr_addr,
  input  logic        scr_cs,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic [17:0] obj_addr,
  input  logic        obj_cs,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_rd,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_dout
);

  state_t      state_r;
  logic        sel_r;
  logic        ptr_r;
  logic [17:0] req_addr_r;
  logic [15:0] buf_r;

  logic        miss_scr_s, miss_obj_s, contest_s, grant_s;
  logic        fill_s, fill_scr_s, fill_obj_s;
  logic [31:0] fill_data_s;
  logic [21:0] scr_word_s, obj_word_s;

  assign miss_scr_s  = scr_cs & ~scr_ok;
  assign miss_obj_s  = obj_cs & ~obj_ok;
  assign contest_s   = miss_scr_s & miss_obj_s;
  assign scr_word_s  = map_addr(scr_addr, SCR_OFFSET);
  assign obj_word_s  = map_addr(obj_addr, OBJ_OFFSET);
  assign fill_s      = (state_r == ST_BEAT1) & sdram_dst;
  assign fill_scr_s  = fill_s & (sel_r == CL_SCR);
  assign fill_obj_s  = fill_s & (sel_r == CL_OBJ);
  assign fill_data_s = {sdram_dout, buf_r};

  // Grant choice: the pointer only matters when both clients miss together
  always_comb begin
    grant_s = CL_SCR;
    if (contest_s) begin
      grant_s = ptr_r;
    end else if (miss_obj_s) begin
      grant_s = CL_OBJ;
    end else begin
      grant_s = CL_SCR;
    end
  end

  // Request/fill sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sel_r      <= CL_SCR;
      ptr_r      <= CL_SCR;
      req_addr_r <= 18'd0;
      buf_r      <= 16'd0;
      sdram_rd   <= 1'b0;
      sdram_addr <= 22'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_scr_s | miss_obj_s) begin
            sel_r      <= grant_s;
            req_addr_r <= (grant_s == CL_OBJ) ? obj_addr : scr_addr;
            sdram_addr <= (grant_s == CL_OBJ) ? obj_word_s : scr_word_s;
            sdram_rd   <= 1'b1;
            state_r    <= ST_REQ;
            if (contest_s) begin
              ptr_r <= ~grant_s;
            end
          end
        end
        ST_REQ: begin
          // A dst coinciding with the ack is deliberately dropped here
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            state_r  <= ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          if (sdram_dst) begin
            buf_r   <= sdram_dout;
            state_r <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (sdram_dst) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          sdram_rd <= 1'b0;
        end
      endcase
    end
  end

  jtkiwi_romrq_slot u_scr (
    .rst       (rst),
    .clk       (clk),
    .addr      (scr_addr),
    .cs        (scr_cs),
    .fill      (fill_scr_s),
    .fill_tag  (req_addr_r),
    .fill_data (fill_data_s),
    .ok        (scr_ok),
    .data      (scr_data)
  );

  jtkiwi_romrq_slot u_obj (
    .rst       (rst),
    .clk       (clk),
    .addr      (obj_addr),
    .cs        (obj_cs),
    .fill      (fill_obj_s),
    .fill_tag  (req_addr_r),
    .fill_data (fill_data_s),
    .ok        (obj_ok),
    .data      (obj_data)
  );

endmodule

// File: tb/tb_jtkiwi_gfx_romrq.sv
// Directed bench for jtkiwi_gfx_romrq: miss table plus hand-written corner sequences.
module tb_jtkiwi_gfx_romrq;

  logic        rst, clk;
  logic [17:0] scr_addr, obj_addr;
  logic        scr_cs, obj_cs;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_rd, sdram_ack, sdram_dst;
  logic [15:0] sdram_dout;

  logic [17:0] w_scr_addr, w_obj_addr;
  logic        w_scr_cs, w_obj_cs;
  logic [31:0] w_scr_data, w_obj_data;
  logic        w_scr_ok, w_obj_ok;
  logic [21:0] w_sdram_addr;
  logic        w_sdram_rd, w_sdram_ack, w_sdram_dst;
  logic [15:0] w_sdram_dout;

  int total = 0;
  int bad   = 0;

  jtkiwi_gfx_romrq dut (
    .rst(rst), .clk(clk),
    .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_dout(sdram_dout)
  );

  jtkiwi_gfx_romrq #(.OBJ_OFFSET(22'h3FFFFE)) dut_wrap (
    .rst(rst), .clk(clk),
    .scr_addr(w_scr_addr), .scr_cs(w_scr_cs), .scr_data(w_scr_data), .scr_ok(w_scr_ok),
    .obj_addr(w_obj_addr), .obj_cs(w_obj_cs), .obj_data(w_obj_data), .obj_ok(w_obj_ok),
    .sdram_addr(w_sdram_addr), .sdram_rd(w_sdram_rd), .sdram_ack(w_sdram_ack),
    .sdram_dst(w_sdram_dst), .sdram_dout(w_sdram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cl;
    logic [17:0] addr;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [21:0] exp_sa;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Bounded wait for a read request on the main instance
  task automatic wait_rd();
    int n;
    n = 0;
    @(negedge clk);
    while (!sdram_rd && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk("rd_seen", {31'd0, sdram_rd}, 32'd1);
  endtask

  // Ack the pending request and deliver two beats; checks ok timing and data
  task automatic serve(input logic cl, input logic [15:0] b0, input logic [15:0] b1);
    @(posedge clk); #1 sdram_ack = 1'b1;
    @(posedge clk); #1 sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_dout = b0;
    @(posedge clk); #1 sdram_dout = b1;
    @(negedge clk);
    chk("ok_before_fill", {31'd0, (cl ? obj_ok : scr_ok)}, 32'd0);
    @(posedge clk); #1 sdram_dst = 1'b0;
    @(negedge clk);
    chk("ok_after_fill", {31'd0, (cl ? obj_ok : scr_ok)}, 32'd1);
    chk("data_after_fill", (cl ? obj_data : scr_data), {b1, b0});
  endtask

  initial begin
    int hits, rds;
    vecs[0] = '{1'b0, 18'h00010, 16'h1234, 16'h5678, 22'h000020, 32'h5678_1234};
    vecs[1] = '{1'b1, 18'h00003, 16'hABCD, 16'hEF01, 22'h080006, 32'hEF01_ABCD};
    vecs[2] = '{1'b0, 18'h3FFFF, 16'h0F0F, 16'hF0F0, 22'h07FFFE, 32'hF0F0_0F0F};
    vecs[3] = '{1'b1, 18'h3FFFF, 16'h5A5A, 16'hA5A5, 22'h0FFFFE, 32'hA5A5_5A5A};

    rst = 1'b1;
    scr_addr = 18'd0; obj_addr = 18'd0; scr_cs = 1'b0; obj_cs = 1'b0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_dout = 16'd0;
    w_scr_addr = 18'd0; w_scr_cs = 1'b0; w_obj_addr = 18'd1; w_obj_cs = 1'b1;
    w_sdram_ack = 1'b0; w_sdram_dst = 1'b0; w_sdram_dout = 16'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    chk("rst_obj_ok", {31'd0, obj_ok}, 32'd0);
    chk("rst_scr_data", scr_data, 32'd0);
    chk("rst_obj_data", obj_data, 32'd0);
    chk("rst_rd", {31'd0, sdram_rd}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    rst = 1'b0;

    // Single-client misses from the table
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].cl) begin
        obj_addr = vecs[i].addr; obj_cs = 1'b1;
      end else begin
        scr_addr = vecs[i].addr; scr_cs = 1'b1;
      end
      wait_rd();
      chk("vec_sdram_addr", {10'd0, sdram_addr}, {10'd0, vecs[i].exp_sa});
      serve(vecs[i].cl, vecs[i].b0, vecs[i].b1);
      chk("vec_data", (vecs[i].cl ? obj_data : scr_data), vecs[i].exp_d);
      scr_cs = 1'b0; obj_cs = 1'b0;
    end

    // Held hit: ok stays high, no new request
    scr_addr = 18'h3FFFF; scr_cs = 1'b1;
    hits = 0; rds = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (scr_ok) hits++;
      if (sdram_rd) rds++;
    end
    chk("hit_held", hits, 32'd6);
    chk("hit_no_rd", rds, 32'd0);
    scr_addr = 18'h3FFFE;
    #1 chk("hit_drop", {31'd0, scr_ok}, 32'd0);
    obj_addr = 18'h3FFFF; obj_cs = 1'b1;
    wait_rd();
    chk("redo_addr", {10'd0, sdram_addr}, 32'h0007_FFFC);
    chk("obj_hit_during_fill", {31'd0, obj_ok}, 32'd1);
    serve(1'b0, 16'h1111, 16'h2222);
    scr_cs = 1'b0; obj_cs = 1'b0;

    // Simultaneous misses, pointer at scr
    scr_addr = 18'd1; obj_addr = 18'd2; scr_cs = 1'b1; obj_cs = 1'b1;
    wait_rd();
    chk("rr1_first", {10'd0, sdram_addr}, 32'h0000_0002);
    serve(1'b0, 16'h0001, 16'h0002);
    wait_rd();
    chk("rr1_second", {10'd0, sdram_addr}, 32'h0008_0004);
    serve(1'b1, 16'h0003, 16'h0004);
    scr_addr = 18'd7; obj_addr = 18'd8;
    wait_rd();
    chk("rr2_first", {10'd0, sdram_addr}, 32'h0008_0010);
    serve(1'b1, 16'h0005, 16'h0006);
    wait_rd();
    chk("rr2_second", {10'd0, sdram_addr}, 32'h0000_000E);
    serve(1'b0, 16'h0007, 16'h0008);
    scr_cs = 1'b0; obj_cs = 1'b0;

    // Address change during BEAT0
    obj_addr = 18'd5; obj_cs = 1'b1;
    wait_rd();
    chk("chg_addr", {10'd0, sdram_addr}, 32'h0008_000A);
    @(posedge clk); #1 sdram_ack = 1'b1;
    @(posedge clk); #1 sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_dout = 16'hAAAA; obj_addr = 18'd6;
    @(posedge clk); #1 sdram_dout = 16'hBBBB;
    @(posedge clk); #1 sdram_dst = 1'b0;
    @(negedge clk);
    chk("chg_ok_low", {31'd0, obj_ok}, 32'd0);
    chk("chg_data", obj_data, 32'hBBBB_AAAA);
    obj_addr = 18'd5;
    #1 chk("chg_old_tag", {31'd0, obj_ok}, 32'd1);
    obj_addr = 18'd6;
    wait_rd();
    chk("chg_reissue", {10'd0, sdram_addr}, 32'h0008_000C);
    serve(1'b1, 16'hCCCC, 16'hDDDD);

    // Reset while in BEAT0, stray dst afterwards
    obj_addr = 18'd9;
    wait_rd();
    chk("rst_req_addr", {10'd0, sdram_addr}, 32'h0008_0012);
    @(posedge clk); #1 sdram_ack = 1'b1;
    @(posedge clk); #1 sdram_ack = 1'b0;
    rst = 1'b1; scr_cs = 1'b0; obj_cs = 1'b0;
    @(posedge clk); #1 rst = 1'b0; sdram_dst = 1'b1; sdram_dout = 16'hFFFF;
    @(posedge clk); #1 sdram_dst = 1'b0;
    rds = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sdram_rd) rds++;
    end
    chk("mid_rst_no_rd", rds, 32'd0);
    chk("mid_rst_scr_data", scr_data, 32'd0);
    chk("mid_rst_obj_data", obj_data, 32'd0);
    obj_addr = 18'd6; obj_cs = 1'b1;
    #1 chk("mid_rst_valid_clr", {31'd0, obj_ok}, 32'd0);
    wait_rd();
    chk("mid_rst_req", {10'd0, sdram_addr}, 32'h0008_000C);
    serve(1'b1, 16'h4321, 16'h8765);
    obj_cs = 1'b0;

    // Offset wrap on the second instance
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!w_sdram_rd && n < 32) begin
        @(negedge clk);
        n++;
      end
      chk("wrap_rd", {31'd0, w_sdram_rd}, 32'd1);
      chk("wrap_addr", {10'd0, w_sdram_addr}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
